// File: rtl/mem_wb_if.sv
// Data-memory request/response bus between the MEM/WB unit (master) and the data memory (slave).
interface mem_wb_if #(
    parameter int XLEN = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_wb_unit.sv
// MEM/WB stage: data-memory access with lane handling, alignment/legality checks and timeout,
// followed by a registered register-file writeback.
module mem_wb_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [1:0]      mem_to_reg,
    input  logic            reg_write,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] pc_imm,
    input  logic [XLEN-1:0] pc_plus4,
    mem_wb_if.master        dmem,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            exc_misalign,
    output logic            exc_illegal,
    output logic            exc_bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, MEM = 1'b1} state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            in_ready_r, in_ready_s;
    logic            req_r, req_s, we_r, we_s;
    logic [XLEN-1:0] addr_r, addr_s, wdata_r, wdata_s;
    logic [3:0]      be_r, be_s;
    logic            is_load_r, is_load_s, ld_wen_r, ld_wen_s;
    logic [2:0]      ld_f3_r, ld_f3_s;
    logic [1:0]      ld_off_r, ld_off_s;
    logic [4:0]      ld_rd_r, ld_rd_s;
    logic            wb_en_r, wb_en_s;
    logic [4:0]      wb_rd_r, wb_rd_s;
    logic [XLEN-1:0] wb_data_r, wb_data_s;
    logic            exc_mis_r, exc_mis_s, exc_ill_r, exc_ill_s, exc_bus_r, exc_bus_s;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = !is_store;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] size, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                     input logic [XLEN-1:0] d);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] v;
        case (off)
            2'b00:   b = d[7:0];
            2'b01:   b = d[15:8];
            2'b10:   b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  v = {{24{b[7]}}, b};
            3'b001:  v = {{16{h[15]}}, h};
            3'b100:  v = {24'h000000, b};
            3'b101:  v = {16'h0000, h};
            default: v = d;
        endcase
        return v;
    endfunction

    // Next-state, memory-bus and writeback/exception decisions.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        req_s     = req_r;
        we_s      = we_r;
        addr_s    = addr_r;
        be_s      = be_r;
        wdata_s   = wdata_r;
        is_load_s = is_load_r;
        ld_wen_s  = ld_wen_r;
        ld_f3_s   = ld_f3_r;
        ld_off_s  = ld_off_r;
        ld_rd_s   = ld_rd_r;
        wb_en_s   = 1'b0;
        wb_rd_s   = wb_rd_r;
        wb_data_s = wb_data_r;
        exc_mis_s = 1'b0;
        exc_ill_s = 1'b0;
        exc_bus_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    if (!mem_read && !mem_write) begin
                        wb_en_s = reg_write && (rd != 5'd0);
                        if (wb_en_s) begin
                            wb_rd_s = rd;
                            case (mem_to_reg)
                                2'b00:   wb_data_s = alu_result;
                                2'b10:   wb_data_s = pc_imm;
                                2'b11:   wb_data_s = pc_plus4;
                                default: wb_data_s = '0;
                            endcase
                        end else begin
                            wb_rd_s = wb_rd_r;
                        end
                    end else if (mem_read && mem_write) begin
                        exc_ill_s = 1'b1;
                    end else if (!f3_legal(mem_write, funct3)) begin
                        exc_ill_s = 1'b1;
                    end else if (misaligned(funct3[1:0], alu_result[1:0])) begin
                        exc_mis_s = 1'b1;
                    end else begin
                        state_s   = MEM;
                        cnt_s     = '0;
                        req_s     = 1'b1;
                        we_s      = mem_write;
                        addr_s    = {alu_result[XLEN-1:2], 2'b00};
                        be_s      = lane_be(funct3[1:0], alu_result[1:0]);
                        wdata_s   = lane_wdata(funct3[1:0], rs2_data);
                        is_load_s = mem_read;
                        ld_wen_s  = reg_write && (rd != 5'd0);
                        ld_f3_s   = funct3;
                        ld_off_s  = alu_result[1:0];
                        ld_rd_s   = rd;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MEM: begin
                // A ready on the final count still completes normally.
                if (dmem.dmem_ready) begin
                    state_s = IDLE;
                    req_s   = 1'b0;
                    if (is_load_r && ld_wen_r) begin
                        wb_en_s   = 1'b1;
                        wb_rd_s   = ld_rd_r;
                        wb_data_s = load_extract(ld_f3_r, ld_off_r, dmem.dmem_rdata);
                    end else begin
                        wb_en_s = 1'b0;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_s   = IDLE;
                    req_s     = 1'b0;
                    exc_bus_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = IDLE;
                req_s   = 1'b0;
            end
        endcase
        in_ready_s = (state_s == IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            in_ready_r <= 1'b1;
            req_r      <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            be_r       <= 4'b0000;
            wdata_r    <= '0;
            is_load_r  <= 1'b0;
            ld_wen_r   <= 1'b0;
            ld_f3_r    <= 3'b000;
            ld_off_r   <= 2'b00;
            ld_rd_r    <= 5'd0;
            wb_en_r    <= 1'b0;
            wb_rd_r    <= 5'd0;
            wb_data_r  <= '0;
            exc_mis_r  <= 1'b0;
            exc_ill_r  <= 1'b0;
            exc_bus_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            in_ready_r <= in_ready_s;
            req_r      <= req_s;
            we_r       <= we_s;
            addr_r     <= addr_s;
            be_r       <= be_s;
            wdata_r    <= wdata_s;
            is_load_r  <= is_load_s;
            ld_wen_r   <= ld_wen_s;
            ld_f3_r    <= ld_f3_s;
            ld_off_r   <= ld_off_s;
            ld_rd_r    <= ld_rd_s;
            wb_en_r    <= wb_en_s;
            wb_rd_r    <= wb_rd_s;
            wb_data_r  <= wb_data_s;
            exc_mis_r  <= exc_mis_s;
            exc_ill_r  <= exc_ill_s;
            exc_bus_r  <= exc_bus_s;
        end
    end

    assign in_ready        = in_ready_r;
    assign dmem.dmem_req   = req_r;
    assign dmem.dmem_we    = we_r;
    assign dmem.dmem_addr  = addr_r;
    assign dmem.dmem_be    = be_r;
    assign dmem.dmem_wdata = wdata_r;
    assign wb_en           = wb_en_r;
    assign wb_rd           = wb_rd_r;
    assign wb_data         = wb_data_r;
    assign exc_misalign    = exc_mis_r;
    assign exc_illegal     = exc_ill_r;
    assign exc_bus         = exc_bus_r;
endmodule

// File: tb/tb_mem_wb_unit.sv
// Randomized self-checking bench for mem_wb_unit against an arithmetic reference model.
module tb_mem_wb_unit;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, mem_read, mem_write, reg_write;
    logic [1:0]  mem_to_reg;
    logic [2:0]  funct3;
    logic [4:0]  rd, wb_rd;
    logic [31:0] alu_result, rs2_data, pc_imm, pc_plus4, wb_data;
    logic        wb_en, exc_misalign, exc_illegal, exc_bus;
    int          total = 0;
    int          bad = 0;

    mem_wb_if #(.XLEN(32)) bus ();

    mem_wb_unit #(.XLEN(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .funct3(funct3), .rd(rd), .alu_result(alu_result),
        .rs2_data(rs2_data), .pc_imm(pc_imm), .pc_plus4(pc_plus4), .dmem(bus),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .exc_misalign(exc_misalign),
        .exc_illegal(exc_illegal), .exc_bus(exc_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // 0 = non-memory, 1 = illegal, 2 = misaligned, 3 = performs an access
    function automatic int classify(input logic mr, input logic mw, input logic [2:0] f3,
                                    input logic [31:0] addr);
        int nbytes;
        if (!mr && !mw) return 0;
        if (mr && mw) return 1;
        if (mr && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1;
        if (mw && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1;
        nbytes = 1 << (int'(f3) % 4);
        if ((addr % nbytes) != 0) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int          nbytes;
        logic [31:0] v;
        nbytes = 1 << (int'(f3) % 4);
        v = word >> (8 * (addr % 4));
        if (nbytes < 4) begin
            v = v % (32'd1 << (8 * nbytes));
            if (f3 < 3'd4 && v >= (32'd1 << (8 * nbytes - 1)))
                v = v - (32'd1 << (8 * nbytes));
        end
        return v;
    endfunction

    task automatic run_op(input logic mr, input logic mw, input logic [1:0] m2r, input logic rw,
                          input logic [2:0] f3, input logic [4:0] rdv, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [31:0] pci, input logic [31:0] pc4,
                          input int lat, input logic [31:0] rword);
        int          kind, nb;
        logic        exp_en;
        logic [31:0] exp_wb, exp_addr, exp_wd;
        logic [7:0]  b8;
        logic [15:0] h16;
        kind = classify(mr, mw, f3, alu);
        nb   = 1 << (int'(f3) % 4);
        exp_addr = alu & 32'hFFFF_FFFC;
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        mem_read = mr; mem_write = mw; mem_to_reg = m2r; reg_write = rw; funct3 = f3; rd = rdv;
        alu_result = alu; rs2_data = rs2; pc_imm = pci; pc_plus4 = pc4;
        in_valid = 1'b1;
        bus.dmem_ready = 1'($urandom % 2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        bus.dmem_ready = 1'b0;
        if (kind == 0) begin
            exp_en = rw && (rdv != 5'd0);
            exp_wb = (m2r == 2'd0) ? alu : (m2r == 2'd2) ? pci : (m2r == 2'd3) ? pc4 : 32'd0;
            chk("alu_wb_en", {31'd0, wb_en}, {31'd0, exp_en});
            if (exp_en) begin
                chk("alu_wb_rd", {27'd0, wb_rd}, {27'd0, rdv});
                chk("alu_wb_data", wb_data, exp_wb);
            end
            chk("alu_no_req", {31'd0, bus.dmem_req}, 32'd0);
            chk("alu_no_exc", {29'd0, exc_illegal, exc_misalign, exc_bus}, 32'd0);
        end else if (kind == 1 || kind == 2) begin
            chk("exc_kind", {29'd0, exc_illegal, exc_misalign, exc_bus},
                (kind == 1) ? 32'd4 : 32'd2);
            chk("exc_no_wb", {31'd0, wb_en}, 32'd0);
            chk("exc_no_req", {31'd0, bus.dmem_req}, 32'd0);
        end else begin
            b8  = rs2[7:0];
            h16 = rs2[15:0];
            exp_wd = (nb == 1) ? b8 * 32'h0101_0101 : (nb == 2) ? h16 * 32'h0001_0001 : rs2;
            chk("acc_req", {31'd0, bus.dmem_req}, 32'd1);
            chk("acc_we", {31'd0, bus.dmem_we}, {31'd0, mw});
            chk("acc_addr", bus.dmem_addr, exp_addr);
            chk("acc_be", {28'd0, bus.dmem_be}, ((32'd1 << nb) - 32'd1) << (alu % 4));
            if (mw) chk("acc_wdata", bus.dmem_wdata, exp_wd);
            chk("acc_busy", {31'd0, in_ready}, 32'd0);
            for (int k = 1; k <= TMO; k++) begin
                @(negedge clk);
                bus.dmem_ready = (k == lat);
                bus.dmem_rdata = (k == lat) ? rword : $urandom;
                @(posedge clk); #1;
                bus.dmem_ready = 1'b0;
                if (k == lat) begin
                    exp_en = mr && rw && (rdv != 5'd0);
                    chk("done_req", {31'd0, bus.dmem_req}, 32'd0);
                    chk("done_ready", {31'd0, in_ready}, 32'd1);
                    chk("done_no_exc", {29'd0, exc_illegal, exc_misalign, exc_bus}, 32'd0);
                    chk("done_wb_en", {31'd0, wb_en}, {31'd0, exp_en});
                    if (exp_en) begin
                        chk("load_wb_rd", {27'd0, wb_rd}, {27'd0, rdv});
                        chk("load_wb_data", wb_data, ext_load(f3, alu, rword));
                    end
                    break;
                end else if (k == TMO) begin
                    chk("tmo_req", {31'd0, bus.dmem_req}, 32'd0);
                    chk("tmo_exc", {29'd0, exc_illegal, exc_misalign, exc_bus}, 32'd1);
                    chk("tmo_no_wb", {31'd0, wb_en}, 32'd0);
                    chk("tmo_ready", {31'd0, in_ready}, 32'd1);
                end else begin
                    chk("wait_req", {31'd0, bus.dmem_req}, 32'd1);
                    chk("wait_addr", bus.dmem_addr, exp_addr);
                    chk("wait_busy", {31'd0, in_ready}, 32'd0);
                    chk("wait_no_wb", {31'd0, wb_en | exc_bus}, 32'd0);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic        mr, mw;
        logic [2:0]  f3;
        int          cls;
        rst = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 2'd0;
        reg_write = 1'b0; funct3 = 3'd0; rd = 5'd0; alu_result = '0; rs2_data = '0;
        pc_imm = '0; pc_plus4 = '0; bus.dmem_ready = 1'b0; bus.dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_outs", {27'd0, bus.dmem_req, wb_en, exc_illegal, exc_misalign, exc_bus}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // back-to-back non-memory ops: JAL link then ALU result
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b1; rd = 5'd5;
        mem_to_reg = 2'b11; pc_plus4 = 32'h104; alu_result = 32'hDEAD_0001; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b_wb0", {31'd0, wb_en}, 32'd1);
        chk("b2b_data0", wb_data, 32'h104);
        chk("b2b_ready0", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        mem_to_reg = 2'b00; alu_result = 32'h0000_BEEF; rd = 5'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_wb1", {31'd0, wb_en}, 32'd1);
        chk("b2b_data1", wb_data, 32'h0000_BEEF);
        chk("b2b_rd1", {27'd0, wb_rd}, 32'd6);

        // directed memory cases
        run_op(1, 0, 2'b01, 1, 3'b000, 5'd7, 32'h1003, 0, 0, 0, 3, 32'h8012_3456);
        run_op(1, 0, 2'b01, 1, 3'b100, 5'd7, 32'h1003, 0, 0, 0, 3, 32'h8012_3456);
        run_op(0, 1, 2'b00, 0, 3'b001, 5'd0, 32'h2002, 32'h1234_ABCD, 0, 0, 2, 32'h0);
        run_op(1, 0, 2'b01, 1, 3'b010, 5'd3, 32'h2001, 0, 0, 0, 1, 32'h0);
        run_op(1, 1, 2'b01, 1, 3'b010, 5'd3, 32'h2000, 0, 0, 0, 1, 32'h0);
        run_op(1, 0, 2'b01, 1, 3'b011, 5'd3, 32'h2000, 0, 0, 0, 1, 32'h0);
        run_op(1, 0, 2'b01, 1, 3'b010, 5'd9, 32'h3000, 0, 0, 0, 99, 32'h0);
        run_op(1, 0, 2'b01, 1, 3'b010, 5'd9, 32'h3000, 0, 0, 0, TMO, 32'hCAFE_F00D);
        run_op(1, 0, 2'b01, 1, 3'b010, 5'd0, 32'h3004, 0, 0, 0, 1, 32'h1111_2222);

        // reset while an access is outstanding
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; rd = 5'd4; reg_write = 1'b1;
        alu_result = 32'h4000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_req", {31'd0, bus.dmem_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        bus.dmem_ready = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_pulses", {28'd0, wb_en, exc_illegal, exc_misalign, exc_bus}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.dmem_ready = 1'b0;

        for (int n = 0; n < 300; n++) begin
            cls = $urandom % 8;
            mr  = (cls inside {1, 2, 3, 7});
            mw  = (cls inside {4, 5, 7});
            f3  = ($urandom % 4 == 0) ? 3'($urandom) : (mr ? 3'($urandom % 3) : 3'($urandom % 3));
            if (mr && !mw && ($urandom % 3 == 0)) f3 = 3'd4 + 3'($urandom % 2);
            run_op(mr, mw, 2'($urandom), 1'($urandom % 4 != 0), f3, 5'($urandom), $urandom,
                   $urandom, $urandom, $urandom, $urandom_range(1, 6), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_wb_unit.md
Name: mem_wb_unit

Overview:
- Consumes the per-instruction control word produced by the main control decoder (MemRead, MemWrite, MemtoReg, RegWrite) plus EX-stage results.
- Performs the data-memory access over a req/ready handshake, with byte lanes, load extension, alignment checks and a timeout.
- Selects and registers the writeback value for the register file.
- Sits between the EX stage and the register-file write port; stalls upstream while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- TIMEOUT, 64, maximum cycles waiting for dmem_ready before abort; must be ≥ 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  EX-stage instruction valid.
- in_ready  out  1  unit can accept an instruction this cycle.
- mem_read  in  1  MemRead control.
- mem_write  in  1  MemWrite control.
- mem_to_reg  in  2  writeback select: 00 alu_result, 01 load data, 10 pc_imm, 11 pc_plus4.
- reg_write  in  1  RegWrite control.
- funct3  in  3  access size/sign.
- rd  in  5  destination register.
- alu_result  in  32  ALU result / effective address.
- rs2_data  in  32  store data.
- pc_imm  in  32  PC+imm (AUIPC).
- pc_plus4  in  32  link value.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address ({alu_result[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ready  in  1  request accepted/completed; dmem_rdata valid on loads.
- dmem_rdata  in  32  load word.
- wb_en  out  1  register-file write strobe (1-cycle pulse).
- wb_rd  out  5  write address.
- wb_data  out  32  write data.
- exc_misalign  out  1  1-cycle pulse: misaligned access.
- exc_illegal  out  1  1-cycle pulse: bad funct3, or mem_read&mem_write.
- exc_bus  out  1  1-cycle pulse: timeout.

Behaviour:
- Reset: state IDLE.
  - All outputs 0 except in_ready, which is 1.
  - Reset mid-access drops dmem_req on the next edge; no writeback or exception is issued.
- FSM states: IDLE, MEM.
  - in_ready = 1 only in IDLE.
  - An instruction is accepted when in_valid & in_ready.
- IDLE, accepted instruction that is non-memory (mem_read = mem_write = 0):
  - Next cycle: wb_en = reg_write & (rd != 0).
  - wb_data is selected by mem_to_reg; mem_to_reg = 01 without mem_read yields 0.
  - State stays IDLE (1-cycle latency, full throughput).
- IDLE, accepted instruction that is a memory op, checked in this order:
  - mem_read & mem_write → exc_illegal.
  - Loads: funct3 not in {000,001,010,100,101} → exc_illegal.
  - Stores: funct3 not in {000,001,010} → exc_illegal.
  - Halfword with addr[0] = 1, or word with addr[1:0] != 0 → exc_misalign.
  - Any of the above: the exception pulses next cycle, with no access and no writeback.
  - Otherwise: next cycle dmem_req = 1 with registered we/addr/be/wdata, timeout counter cleared, go to MEM.
- Byte enables and store data:
  - Byte: be = 0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011; wdata = {2{rs2[15:0]}}.
  - Word: be = 1111; wdata = rs2.
- MEM:
  - dmem_req and all dmem_* outputs are held stable until dmem_ready.
  - On dmem_ready: dmem_req drops on the next edge and the state returns to IDLE.
  - For loads, on that same edge: wb_en = (rd != 0) & reg_write; wb_data = extracted lane of dmem_rdata.
  - Extraction: byte selected by addr[1:0], half by addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
  - Stores produce no writeback.
  - Each cycle without ready increments the counter. When the counter reaches TIMEOUT-1 and dmem_ready is still 0: abort, exc_bus pulse, no writeback, return to IDLE.
  - dmem_ready arriving on the same cycle as the timeout count wins (normal completion).
- dmem_ready while in IDLE is ignored.
- wb_en and the exc_* outputs are 1-cycle pulses; wb_rd and wb_data hold their last value otherwise.
- Accepted-to-writeback latency: non-memory 1 cycle; load N+1 cycles, where N = cycles from dmem_req high to dmem_ready.

Test Plan:
1. Non-memory op (mem_to_reg = 11, pc_plus4 = 0x104, rd = 5, reg_write = 1), then an ALU op back-to-back → wb_en pulses on consecutive cycles with 0x104 then alu_result; in_ready stays 1.
2. LB at addr 0x1003, dmem_rdata = 0x80xxxxxx, ready after 3 cycles → dmem_addr = 0x1000, be = 1000, req held for 3 cycles, wb_data = 0xFFFFFF80; LBU of the same gives 0x00000080.
3. SH at addr 0x2002, rs2 = 0x1234ABCD → be = 1100, wdata = 0xABCDABCD, we = 1, no wb_en, in_ready low until ready.
4. LW at 0x2001 → exc_misalign pulse, dmem_req never rises; mem_read = mem_write = 1 → exc_illegal; load funct3 = 011 → exc_illegal.
5. TIMEOUT = 4, ready never asserted → req high for exactly 4 cycles, then exc_bus pulse, return to IDLE; separately, ready on the 4th cycle → normal completion with no exc_bus.
6. rst asserted during MEM → dmem_req low and in_ready high after the edge, with no wb_en or exc pulses; a load to rd = 0 → wb_en stays 0.
